// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: stepped sphere-tracing controller, one ray at a time over a shared SDF evaluator.
// Define RAYMARCH_WDOG_EN to enable the SDF response watchdog (res_err).
module ray_march_ctrl #(
  parameter int          MAX_STEPS    = 100,
  parameter logic [31:0] MAX_DIST     = 32'h0064_0000,
  parameter logic [31:0] SURFACE_DIST = 32'h0000_028F,
  parameter int          WDOG_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [95:0] ro,
  input  logic [95:0] rd,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [95:0] q_pos,
  input  logic        r_valid,
  input  logic [31:0] r_dist,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_dist,
  output logic        res_hit,
  output logic [7:0]  res_steps,
  output logic        res_err
);
  typedef enum logic [2:0] {IDLE, CALC, QUERY, WAIT, UPDATE, DONE} state_t;
  state_t state, state_n;
  logic [95:0] ro_r, rd_r;
  logic [31:0] t, ds, t_new;
  logic [32:0] sum;
  logic [7:0]  step;
  logic        hit, stop, tmo;

  // o + d*t with the Q16.16 product truncated to bits [47:16]
  function automatic logic [31:0] axis(input logic [31:0] o, input logic [31:0] d, input logic [31:0] s);
    return o + 32'(($signed({{32{d[31]}}, d}) * $signed({{32{s[31]}}, s})) >>> 16);
  endfunction

  always_comb begin
    sum   = {t[31], t} + {ds[31], ds};
    t_new = (sum[32:31] == 2'b01) ? 32'h7FFF_FFFF : (sum[32:31] == 2'b10) ? 32'h8000_0000 : sum[31:0];
    hit   = $signed(ds) < $signed(SURFACE_DIST);
    stop  = hit || ($signed(t_new) > $signed(MAX_DIST)) || (step == 8'(MAX_STEPS));
    ray_ready = state == IDLE;
    q_valid   = state == QUERY;
    res_valid = state == DONE;
  end

`ifdef RAYMARCH_WDOG_EN
  logic [31:0] wcnt;
  always_ff @(posedge clk)
    wcnt <= (rst || state != WAIT) ? 32'd0 : wcnt + 32'd1;
  assign tmo = (state == WAIT) && !r_valid && (wcnt == 32'(WDOG_CYCLES - 1));
`else
  assign tmo = 1'b0 && (WDOG_CYCLES > 0);
`endif

  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ray_valid ? CALC : IDLE;
      CALC:    state_n = QUERY;
      QUERY:   state_n = q_ready ? WAIT : QUERY;
      WAIT:    state_n = r_valid ? UPDATE : tmo ? DONE : WAIT;
      UPDATE:  state_n = stop ? DONE : CALC;
      DONE:    state_n = res_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ro_r      <= '0;
      rd_r      <= '0;
      t         <= '0;
      ds        <= '0;
      step      <= '0;
      q_pos     <= '0;
      res_dist  <= '0;
      res_hit   <= 1'b0;
      res_steps <= '0;
      res_err   <= 1'b0;
    end else begin
      if (state == IDLE && ray_valid) begin
        ro_r <= ro;
        rd_r <= rd;
        t    <= '0;
        step <= '0;
      end
      if (state == CALC)
        q_pos <= {axis(ro_r[95:64], rd_r[95:64], t), axis(ro_r[63:32], rd_r[63:32], t), axis(ro_r[31:0], rd_r[31:0], t)};
      if (state == QUERY && q_ready)
        step <= step + 8'd1;
      if (state == WAIT && r_valid)
        ds <= r_dist;
      if (tmo) begin
        res_dist  <= t;
        res_hit   <= 1'b0;
        res_steps <= step;
        res_err   <= 1'b1;
      end
      if (state == UPDATE) begin
        t <= t_new;
        if (stop) begin
          res_dist  <= t_new;
          res_hit   <= hit;
          res_steps <= step;
          res_err   <= 1'b0;
        end
      end
    end
  end
endmodule
